// File: rtl/clksel_pkg.sv
// Shared types and constants for the clock-select request controller.
package clksel_pkg;

  typedef enum logic [1:0] {
    LS    = 2'd0,
    TO_HS = 2'd1,
    HS    = 2'd2,
    TO_LS = 2'd3
  } clksel_state_e;

  localparam int CFG_TURBO_BIT = 0;
  localparam int CFG_DIV_LSB   = 1;
  localparam int CFG_DIV_MSB   = 2;

  localparam logic [1:0] DIV_RESET_DEF = 2'b11;

  // Bank-0 pages inside [lo, hi] must run on the motherboard clock.
  function automatic logic page_is_slow(input logic [7:0] bank,
                                        input logic [7:0] page,
                                        input logic [7:0] lo,
                                        input logic [7:0] hi);
    return (bank == 8'h00) && (page >= lo) && (page <= hi);
  endfunction

endpackage

// File: rtl/clksel_ctrl_if.sv
// CPU-side bus into the clock-select controller: address decode strobe,
// config write port and the ready/stall line back to the CPU.
interface clksel_ctrl_if;
  logic       addr_valid;
  logic [7:0] bank;
  logic [7:0] addr_hi;
  logic       cfg_wr;
  logic [2:0] cfg_data;
  logic       cpu_rdy;

  modport master (
    output addr_valid, bank, addr_hi, cfg_wr, cfg_data,
    input  cpu_rdy
  );

  modport slave (
    input  addr_valid, bank, addr_hi, cfg_wr, cfg_data,
    output cpu_rdy
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for a level from another clock domain, with a
// selectable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clksel_ctrl.sv
// Clock-select request controller: decodes CPU cycles into hs/ls clock requests
// and stalls the CPU on downward switches. Optional watchdog: CLKSEL_TIMEOUT_EN.
//
// state | meaning
// LS    | running on the low-speed clock, dwell timer counting down
// TO_HS | hs requested, waiting for the switch to report hs selected
// HS    | running on the high-speed clock
// TO_LS | ls requested, waiting for ls selected and hs released
module clksel_ctrl
  import clksel_pkg::*;
#(
  parameter logic [7:0]  SLOW_PAGE_LO  = 8'hFC,
  parameter logic [7:0]  SLOW_PAGE_HI  = 8'hFE,
  parameter int unsigned MIN_LS_CYCLES = 8,
  parameter logic [1:0]  DIV_RESET     = DIV_RESET_DEF
`ifdef CLKSEL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic             clk_in,
  input  logic             rst,
  clksel_ctrl_if.slave     bus,
  input  logic             hsclk_selected,
  input  logic             lsclk_selected,
  output logic             hsclk_sel,
  output logic [1:0]       cpuclk_div_sel,
  output logic             switching,
  output logic             timeout_err
);

  localparam logic [7:0] DWELL_INIT = 8'(MIN_LS_CYCLES);

  clksel_state_e state, state_n;
  logic          hs_ack, ls_ack;
  logic          slow, fast;
  logic          turbo_en;
  logic [1:0]    div_pending;
  logic [7:0]    dwell, dwell_n;
  logic          hsclk_sel_n, cpu_rdy, cpu_rdy_n;
  logic          wd_hit;

  sync2 #(.RST_VAL(1'b0)) u_sync_hs (
    .clk (clk_in),
    .rst (rst),
    .d   (hsclk_selected),
    .q   (hs_ack)
  );

  sync2 #(.RST_VAL(1'b1)) u_sync_ls (
    .clk (clk_in),
    .rst (rst),
    .d   (lsclk_selected),
    .q   (ls_ack)
  );

  assign slow = page_is_slow(bus.bank, bus.addr_hi, SLOW_PAGE_LO, SLOW_PAGE_HI);
  assign fast = !slow && turbo_en;

`ifdef CLKSEL_TIMEOUT_EN
  logic [7:0] wd;
  logic       in_switch;
  logic       timeout_err_q;

  assign in_switch = (state == TO_HS) || (state == TO_LS);
  // Fires on the edge where wd becomes TIMEOUT_CYCLES.
  assign wd_hit    = in_switch && (wd == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wd            <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if ((state_n != state) && ((state_n == TO_HS) || (state_n == TO_LS))) begin
        wd <= '0;
      end else if (in_switch && (wd != 8'(TIMEOUT_CYCLES))) begin
        wd <= wd + 8'd1;
      end
      if (wd_hit) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    hsclk_sel_n = hsclk_sel;
    cpu_rdy_n   = cpu_rdy;
    dwell_n     = dwell;
    unique case (state)
      LS: begin
        if (dwell != 8'd0) begin
          dwell_n = dwell - 8'd1;
        end
        if (bus.addr_valid && fast && (dwell == 8'd0)) begin
          state_n     = TO_HS;
          hsclk_sel_n = 1'b1;
        end
      end
      TO_HS: begin
        // A slow access beats every other exit so it never runs on the fast clock.
        if (bus.addr_valid && slow) begin
          state_n     = TO_LS;
          hsclk_sel_n = 1'b0;
          cpu_rdy_n   = 1'b0;
        end else if (wd_hit || !turbo_en) begin
          state_n     = TO_LS;
          hsclk_sel_n = 1'b0;
        end else if (hs_ack) begin
          state_n = HS;
        end
      end
      HS: begin
        if (bus.addr_valid && slow) begin
          state_n     = TO_LS;
          hsclk_sel_n = 1'b0;
          cpu_rdy_n   = 1'b0;
        end else if (!turbo_en) begin
          state_n     = TO_LS;
          hsclk_sel_n = 1'b0;
        end
      end
      TO_LS: begin
        if (ls_ack && !hs_ack) begin
          state_n   = LS;
          cpu_rdy_n = 1'b1;
          dwell_n   = DWELL_INIT;
        end
      end
      default: begin
        state_n     = LS;
        hsclk_sel_n = 1'b0;
        cpu_rdy_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= LS;
      hsclk_sel <= 1'b0;
      cpu_rdy   <= 1'b1;
      switching <= 1'b0;
      dwell     <= DWELL_INIT;
    end else begin
      state     <= state_n;
      hsclk_sel <= hsclk_sel_n;
      cpu_rdy   <= cpu_rdy_n;
      switching <= (state_n == TO_HS) || (state_n == TO_LS);
      dwell     <= dwell_n;
    end
  end

  // The divider only moves while the hs clock is confirmed idle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      turbo_en       <= 1'b0;
      div_pending    <= DIV_RESET;
      cpuclk_div_sel <= DIV_RESET;
    end else begin
      if (bus.cfg_wr) begin
        turbo_en    <= bus.cfg_data[CFG_TURBO_BIT];
        div_pending <= bus.cfg_data[CFG_DIV_MSB:CFG_DIV_LSB];
      end
      if ((state == TO_HS) && wd_hit) begin
        turbo_en <= 1'b0;
      end
      if ((state == LS) && ls_ack) begin
        cpuclk_div_sel <= div_pending;
      end
    end
  end

  assign bus.cpu_rdy = cpu_rdy;

endmodule

// File: tb/tb_clksel_ctrl.sv
// Table-driven bench for clksel_ctrl with a scoreboard queue of expected outputs.
module tb_clksel_ctrl;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       hsclk_selected;
  logic       lsclk_selected;
  logic       hsclk_sel;
  logic [1:0] cpuclk_div_sel;
  logic       switching;
  logic       timeout_err;

  clksel_ctrl_if bus ();

  clksel_ctrl dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .bus            (bus.slave),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .hsclk_sel      (hsclk_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .switching      (switching),
    .timeout_err    (timeout_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         cycles;
    logic       rst;
    logic       av;
    logic [7:0] bank;
    logic [7:0] ahi;
    logic       cw;
    logic [2:0] cd;
    logic       hs;
    logic       ls;
    logic       e_sel;
    logic       e_rdy;
    logic       e_sw;
    logic [1:0] e_div;
  } vec_t;

  typedef struct {
    int         idx;
    logic       e_sel;
    logic       e_rdy;
    logic       e_sw;
    logic [1:0] e_div;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0b expected %0b", name, idx, act, exp);
    end
  endtask

  task automatic add(input int cyc, input logic r, input logic av, input logic [7:0] bank,
                     input logic [7:0] ahi, input logic cw, input logic [2:0] cd,
                     input logic hs, input logic ls, input logic es, input logic er,
                     input logic ew, input logic [1:0] ed);
    vec_t v;
    v.cycles = cyc; v.rst = r; v.av = av; v.bank = bank; v.ahi = ahi;
    v.cw = cw; v.cd = cd; v.hs = hs; v.ls = ls;
    v.e_sel = es; v.e_rdy = er; v.e_sw = ew; v.e_div = ed;
    vt.push_back(v);
  endtask

  task automatic drive(input logic r, input logic av, input logic [7:0] bank, input logic [7:0] ahi,
                       input logic cw, input logic [2:0] cd, input logic hs, input logic ls);
    rst            = r;
    bus.addr_valid = av;
    bus.bank       = bank;
    bus.addr_hi    = ahi;
    bus.cfg_wr     = cw;
    bus.cfg_data   = cd;
    hsclk_selected = hs;
    lsclk_selected = ls;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", -1, 2'd1, 2'd0);
    end else begin
      e = sb.pop_front();
      chk("hsclk_sel", e.idx, {1'b0, hsclk_sel}, {1'b0, e.e_sel});
      chk("cpu_rdy", e.idx, {1'b0, bus.cpu_rdy}, {1'b0, e.e_rdy});
      chk("switching", e.idx, {1'b0, switching}, {1'b0, e.e_sw});
      chk("cpuclk_div_sel", e.idx, cpuclk_div_sel, e.e_div);
      chk("timeout_err", e.idx, {1'b0, timeout_err}, 2'b00);
    end
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    exp_t e;
    for (int c = 0; c < v.cycles; c++) begin
      @(negedge clk_in);
      drive(v.rst, v.av, v.bank, v.ahi, v.cw, v.cd, v.hs, v.ls);
      if (c == v.cycles - 1) begin
        e.idx = idx; e.e_sel = v.e_sel; e.e_rdy = v.e_rdy; e.e_sw = v.e_sw; e.e_div = v.e_div;
        sb.push_back(e);
      end
      @(posedge clk_in);
      #1;
      if (c == v.cycles - 1) compare_out();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'b000, 1'b0, 1'b1);

    //   cyc rst av bank   ahi    cw cd      hs ls  sel rdy sw div
    add(2,  1,  0, 8'h00, 8'h00, 0, 3'b000, 0, 1,  0,  1,  0, 2'b11); // 0 reset
    add(1,  0,  0, 8'h00, 8'h00, 1, 3'b101, 0, 1,  0,  1,  0, 2'b11); // 1 turbo on, div 10 pending
    add(1,  0,  0, 8'h00, 8'h00, 0, 3'b000, 0, 1,  0,  1,  0, 2'b10); // 2 div copied in LS
    add(1,  0,  1, 8'h01, 8'h00, 0, 3'b000, 0, 1,  0,  1,  0, 2'b10); // 3 fast, dwell not expired
    add(5,  0,  0, 8'h00, 8'h00, 0, 3'b000, 0, 1,  0,  1,  0, 2'b10); // 4 dwell runs out
    add(1,  0,  1, 8'h01, 8'h00, 0, 3'b000, 0, 1,  1,  1,  1, 2'b10); // 5 -> TO_HS
    add(2,  0,  0, 8'h00, 8'h00, 0, 3'b000, 1, 0,  1,  1,  1, 2'b10); // 6 ack in flight
    add(1,  0,  0, 8'h00, 8'h00, 0, 3'b000, 1, 0,  1,  1,  0, 2'b10); // 7 -> HS
    add(1,  0,  1, 8'h00, 8'hFB, 0, 3'b000, 1, 0,  1,  1,  0, 2'b10); // 8 FB is fast
    add(1,  0,  1, 8'h00, 8'hFF, 0, 3'b000, 1, 0,  1,  1,  0, 2'b10); // 9 FF is fast
    add(1,  0,  1, 8'h01, 8'hFD, 0, 3'b000, 1, 0,  1,  1,  0, 2'b10); // 10 bank 1 is fast
    add(1,  0,  0, 8'h00, 8'h00, 1, 3'b001, 1, 0,  1,  1,  0, 2'b10); // 11 div 00 pending in HS
    add(3,  0,  0, 8'h00, 8'h00, 0, 3'b000, 1, 0,  1,  1,  0, 2'b10); // 12 divider held
    add(1,  0,  1, 8'h00, 8'hFC, 0, 3'b000, 1, 0,  0,  0,  1, 2'b10); // 13 FC slow -> TO_LS stall
    add(3,  0,  1, 8'h01, 8'h00, 0, 3'b000, 1, 0,  0,  0,  1, 2'b10); // 14 requests ignored in TO_LS
    add(2,  0,  0, 8'h00, 8'h00, 0, 3'b000, 0, 1,  0,  0,  1, 2'b10); // 15 ls ack in flight
    add(1,  0,  0, 8'h00, 8'h00, 0, 3'b000, 0, 1,  0,  1,  0, 2'b10); // 16 -> LS, ready
    add(1,  0,  0, 8'h00, 8'h00, 0, 3'b000, 0, 1,  0,  1,  0, 2'b00); // 17 div now applied
    add(7,  0,  1, 8'h01, 8'h00, 0, 3'b000, 0, 1,  0,  1,  0, 2'b00); // 18 dwell blocks requests
    add(1,  0,  1, 8'h00, 8'hFF, 0, 3'b000, 0, 1,  1,  1,  1, 2'b00); // 19 first honoured request
    add(1,  0,  1, 8'h00, 8'hFE, 0, 3'b000, 0, 1,  0,  0,  1, 2'b00); // 20 FE slow in TO_HS
    add(1,  0,  0, 8'h00, 8'h00, 0, 3'b000, 0, 1,  0,  1,  0, 2'b00); // 21 -> LS
    add(8,  0,  0, 8'h00, 8'h00, 0, 3'b000, 0, 1,  0,  1,  0, 2'b00); // 22 dwell
    add(1,  0,  1, 8'h01, 8'h00, 1, 3'b000, 0, 1,  1,  1,  1, 2'b00); // 23 old turbo=1 used
    add(1,  0,  0, 8'h00, 8'h00, 0, 3'b000, 0, 1,  0,  1,  1, 2'b00); // 24 turbo off -> TO_LS, no stall
    add(1,  0,  0, 8'h00, 8'h00, 0, 3'b000, 0, 1,  0,  1,  0, 2'b00); // 25 -> LS
    add(8,  0,  0, 8'h00, 8'h00, 0, 3'b000, 0, 1,  0,  1,  0, 2'b00); // 26 dwell
    add(1,  0,  1, 8'h01, 8'h00, 1, 3'b101, 0, 1,  0,  1,  0, 2'b00); // 27 old turbo=0 used
    add(1,  0,  0, 8'h00, 8'h00, 0, 3'b000, 0, 1,  0,  1,  0, 2'b10); // 28 div 10 applied
    add(1,  0,  1, 8'h01, 8'h00, 0, 3'b000, 0, 1,  1,  1,  1, 2'b10); // 29 -> TO_HS
    add(3,  0,  0, 8'h00, 8'h00, 0, 3'b000, 1, 0,  1,  1,  0, 2'b10); // 30 -> HS
    add(1,  0,  0, 8'h00, 8'h00, 1, 3'b100, 1, 0,  1,  1,  0, 2'b10); // 31 turbo cleared
    add(1,  0,  0, 8'h00, 8'h00, 0, 3'b000, 1, 0,  0,  1,  1, 2'b10); // 32 -> TO_LS, no stall
    add(3,  0,  0, 8'h00, 8'h00, 0, 3'b000, 0, 1,  0,  1,  0, 2'b10); // 33 -> LS
    add(1,  0,  0, 8'h00, 8'h00, 1, 3'b001, 0, 1,  0,  1,  0, 2'b10); // 34 turbo on, div 00
    add(8,  0,  0, 8'h00, 8'h00, 0, 3'b000, 0, 1,  0,  1,  0, 2'b00); // 35 dwell
    add(1,  0,  1, 8'h00, 8'hFC, 0, 3'b000, 0, 1,  0,  1,  0, 2'b00); // 36 FC slow stays LS
    add(1,  0,  1, 8'h00, 8'hFB, 0, 3'b000, 0, 1,  1,  1,  1, 2'b00); // 37 FB fast -> TO_HS
    add(1,  1,  0, 8'h00, 8'h00, 0, 3'b000, 0, 1,  0,  1,  0, 2'b11); // 38 reset mid-switch

    for (int i = 0; i < vt.size(); i++) begin
      apply_vec(i, vt[i]);
    end

    // Exact dwell length after reset: the 8th consecutive request is the first honoured.
    @(negedge clk_in);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'b001, 1'b0, 1'b1);
    @(posedge clk_in);
    #1;
    k = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_in);
      drive(1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 3'b000, 1'b0, 1'b1);
      @(posedge clk_in);
      #1;
      if (hsclk_sel === 1'b1) begin
        k = n;
        break;
      end
    end
    chk("dwell_request_count", -1, 2'(k), 2'(8));
    n_assert++;
    if (k != 8) begin
      n_fail++;
      $display("FAIL dwell_requests: got %0d expected 8", k);
    end

    // Slow access while hs is still pending: stall and drop the request on the same edge.
    @(negedge clk_in);
    drive(1'b0, 1'b1, 8'h00, 8'hFD, 1'b0, 3'b000, 1'b0, 1'b1);
    @(posedge clk_in);
    #1;
    chk("slow_in_to_hs_sel", -1, {1'b0, hsclk_sel}, 2'b00);
    chk("slow_in_to_hs_rdy", -1, {1'b0, bus.cpu_rdy}, 2'b00);
    @(negedge clk_in);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'b000, 1'b0, 1'b1);
    @(posedge clk_in);
    #1;
    chk("release_rdy", -1, {1'b0, bus.cpu_rdy}, 2'b01);
    chk("release_sw", -1, {1'b0, switching}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
